// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule sequencer: loads a 16-word block, then emits
// W[0..NWORDS-1] over a 16-entry circular buffer with a valid/ready handshake.
module sha256_msg_sched #(
    parameter int NWORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EMIT,
        DONE
    } state_e;

    localparam logic [5:0] TLAST = 6'(NWORDS - 1);

    state_e      state_q;
    logic [3:0]  lc_q;
    logic [5:0]  t_q;
    logic        out_valid_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] w_q [16];

    logic [3:0]  ti;
    logic [3:0]  i2;
    logic [3:0]  i7;
    logic [3:0]  i15;
    logic [3:0]  load_idx_d;
    logic [31:0] w_new_d;
    logic        load_we;
    logic        emit_fire;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Index arithmetic is 4-bit so the circular buffer wraps for free.
    always_comb begin
        ti  = t_q[3:0];
        i2  = ti - 4'd2;
        i7  = ti - 4'd7;
        i15 = ti - 4'd15;
        w_new_d = sig1(w_q[i2]) + w_q[i7] + sig0(w_q[i15]) + w_q[ti];
    end

    assign in_ready   = (state_q == IDLE) || (state_q == LOAD);
    assign out_valid  = out_valid_q;
    assign out_idx    = t_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign out_word   = (t_q < 6'd16) ? w_q[ti] : w_new_d;
    assign load_we    = in_valid && in_ready;
    assign emit_fire  = out_valid_q && out_ready;
    assign load_idx_d = (state_q == IDLE) ? 4'd0 : lc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lc_q        <= 4'd0;
            t_q         <= 6'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (load_we) begin
                        lc_q    <= 4'd1;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (load_we) begin
                        lc_q <= lc_q + 4'd1;
                        if (lc_q == 4'd15) begin
                            t_q         <= 6'd0;
                            out_valid_q <= 1'b1;
                            state_q     <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (emit_fire) begin
                        if (t_q == TLAST) begin
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            t_q <= t_q + 6'd1;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    lc_q    <= 4'd0;
                    t_q     <= 6'd0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Buffer holds data only; its contents are never reset.
    always_ff @(posedge clk) begin
        if (load_we) begin
            w_q[load_idx_d] <= in_word;
        end else if (emit_fire && (t_q >= 6'd16)) begin
            w_q[ti] <= w_new_d;
        end
    end

endmodule

// File: doc/sha256_msg_sched.md
# sha256_msg_sched

Sequencer for the SHA-256 message-schedule stage of the hashing pipeline. It accepts one 512-bit block as sixteen 32-bit words, then emits W[0]..W[NWORDS-1] one word per handshake to the compression rounds. For t ≥ 16 it computes σ0/σ1 using fixed right-rotates and shifts over a 16-entry circular word buffer, so it owns the rotation datapath's sequencing and operand selection.

## Interface
- NWORDS, 64, number of schedule words emitted per block; legal range 16..64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  block can accept a message word.
- in_word  in  32  message word M[i], with i = 0..15 in arrival order.
- out_valid  out  1  out_word/out_idx are valid.
- out_ready  in  1  consumer takes the word.
- out_word  out  32  schedule word W[out_idx].
- out_idx  out  6  schedule index t.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse after the last word is taken.

## Operation
- States:
  - IDLE: no block in progress.
  - LOAD: collecting the 16 message words.
  - EMIT: producing schedule words.
  - DONE: one cycle that raises the done pulse.
- Counters: load counter lc[3:0] and emit counter t[5:0].
- Buffer: buf[0..15], 32 bits each. Buffer contents are not reset.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready, write buf[0]=in_word, set lc=1, and go to LOAD.
- LOAD:
  - in_ready=1.
  - Each accepted word is written to buf[lc] and lc increments.
  - When the word with lc==15 is accepted, set t=0 and go to EMIT.
- EMIT:
  - in_ready=0 and out_valid=1. out_idx=t.
  - For t<16: out_word=buf[t].
  - For t≥16: out_word = σ1(buf[(t-2)%16]) + buf[(t-7)%16] + σ0(buf[(t-15)%16]) + buf[t%16], mod 2^32.
  - σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - ROTR is a 32-bit rotate; SHR is a logical shift with zero fill.
  - On out_valid&&out_ready:
    - If t≥16, write the computed word into buf[t%16], overwriting W[t-16].
    - Increment t.
    - If t==NWORDS-1, go to DONE instead.
- DONE: done=1 for exactly one cycle, then go to IDLE. in_ready=0 during DONE.
- Arithmetic: all sums are 32-bit modulo with carry-out discarded. The buffer index is t[3:0], which wraps naturally.
- Backpressure:
  - While out_valid && !out_ready, out_word and out_idx must stay stable.
  - No buffer write occurs and t does not change.
- in_word is ignored whenever in_ready=0. No input is lost: the producer must hold it until in_ready.
- Reset, asserted at any time (including mid-LOAD or mid-EMIT), immediately produces:
  - state=IDLE, lc=0, t=0;
  - out_valid=0, done=0, busy=0, in_ready=1.
- The partial block is discarded.
- Reset values of outputs:
  - in_ready=1, out_valid=0, out_word=don't-care (masked by out_valid), out_idx=0, busy=0, done=0.

## Timing
- Input acceptance: one word per cycle when in_valid is held high. The 16th word is accepted on cycle k.
- out_valid rises at the clock edge ending cycle k; W[0] is presented in cycle k+1.
- Output throughput: one word per cycle when out_ready=1. W[t] for t≥16 is combinational from registered buffer state, so there is no extra latency.
- Full-rate block: 16 load cycles + NWORDS emit cycles + 1 DONE cycle. With NWORDS=64 this is 81 cycles, after which the next block can be accepted.
- done is asserted the cycle after W[NWORDS-1] is taken. busy falls in the same cycle that done falls.
- The output path is registered control only: out_valid, out_idx and busy are flops. The σ/adder path is a single cycle.

## Test plan
- Message "abc" block:
  - Stimulus: M0=0x61626380, M1..M14=0, M15=0x00000018, with out_ready=1.
  - Required: W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6; out_idx runs 0..63 consecutively; done pulses once, 1 cycle after idx 63.
- Backpressure:
  - Stimulus: same block, with out_ready toggled pseudo-randomly (including holds of 5 or more cycles at t=15, 16 and 63).
  - Required: the word sequence matches the reference model exactly; out_word/out_idx stay stable while stalled.
- Input gaps:
  - Stimulus: in_valid deasserted for 3 cycles between words 7 and 8.
  - Required: identical W sequence; in_ready is 0 throughout EMIT and DONE, and in_valid pulses there are ignored.
- Reset mid-operation:
  - Stimulus: rst_n pulsed low during EMIT at t=30, then a fresh all-zero block is loaded.
  - Required: outputs take reset values immediately; the new block yields W[t]=0 for all t.
- NWORDS=16:
  - Stimulus: instance with NWORDS=16 loaded with M[i]=i.
  - Required: W[i]=i for i=0..15, then done; no computed words are emitted.
- Back-to-back blocks:
  - Stimulus: two blocks with in_valid held high.
  - Required: the second block loads starting the cycle after done; both W sequences are correct and independent.
